ram_read_streamer: RTL and testbench

- Read-side counterpart to the write address generator. The writer's enable pulse marks each word written into a 2^ADDR_WIDTH-entry synchronous RAM; this block counts those words.
- It issues RAM read addresses in the same wrapping order and streams the returned words out on a valid/ready interface.
- It sits between the shared single-port-read RAM and the downstream consumer, and flags occupancy and overflow.

---
 rtl/ram_stream_pkg.sv | 10 +
 rtl/stream_fifo2.sv | 39 +++
 rtl/ram_read_streamer.sv | 77 +++++++
 tb/tb_ram_read_streamer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_pkg.sv
// Shared widths and types for the RAM read-side streamer.
package ram_stream_pkg;
   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEPTH          = 1 << DEF_ADDR_WIDTH;

   typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
   typedef logic [DEF_DATA_WIDTH-1:0] data_t;
   typedef logic [DEF_ADDR_WIDTH:0]   count_t;
endpackage

// File: rtl/stream_fifo2.sv
// Two-entry output FIFO; push and pop may coincide even when full.
module stream_fifo2 #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [1:0]            cnt_o
);
   logic [1:0][DATA_WIDTH-1:0] mem_q;
   logic                       wp_q, rp_q;
   logic [1:0]                 cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '0;
         wp_q  <= 1'b0;
         rp_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wp_q] <= data_i;
            wp_q        <= ~wp_q;
         end
         if (pop_i) rp_q <= ~rp_q;
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign data_o = mem_q[rp_q];
   assign cnt_o  = cnt_q;
endmodule

// File: rtl/ram_read_streamer.sv
// Reads words back from the writer's circular RAM in write order and streams
// them out on valid/ready, with occupancy and sticky overflow flags.
module ram_read_streamer
   import ram_stream_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow
);
   localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  inflight_q;
   logic                  overflow_q, overflow_d;
   logic [1:0]            buf_cnt;
   logic [2:0]            occ;
   logic                  pop, wr_acc;

   // Credit: buffered + in-flight words after this cycle's pop must stay
   // below two, so the 2-entry FIFO can never be overrun.
   always_comb begin
      pop        = out_valid & out_ready;
      occ        = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
      rd_en      = (count_q != '0) && (occ < 3'd2);
      wr_acc     = wr_en && (!full || rd_en);
      count_d    = count_q;
      if (wr_acc && !rd_en)      count_d = count_q + (ADDR_WIDTH+1)'(1);
      else if (!wr_acc && rd_en) count_d = count_q - (ADDR_WIDTH+1)'(1);
      rd_ptr_d   = rd_en ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
      overflow_d = overflow_q | (wr_en & full & ~rd_en);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         inflight_q <= rd_en;
         overflow_q <= overflow_d;
      end
   end

   stream_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
      .clk_i  (clk),
      .rst_ni (rst),
      .push_i (inflight_q),
      .pop_i  (pop),
      .data_i (ram_rdata),
      .data_o (out_data),
      .cnt_o  (buf_cnt)
   );

   assign out_valid = (buf_cnt != 2'd0);
   assign rd_addr   = rd_ptr_q;
   assign count     = count_q;
   assign empty     = (count_q == '0);
   assign full      = (count_q == FULL_CNT);
   assign overflow  = overflow_q;
endmodule

// File: tb/tb_ram_read_streamer.sv
// Random and directed stimulus against a queue-based model of the streamer.
module tb_ram_read_streamer;
   import ram_stream_pkg::*;

   logic   clk = 1'b0, rst = 1'b0, wr_en = 1'b0, out_ready = 1'b0;
   logic   rd_en, out_valid, empty, full, overflow;
   addr_t  rd_addr;
   data_t  ram_rdata, out_data, wdata;
   count_t count;

   always #5 clk = ~clk;

   ram_read_streamer dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .rd_addr(rd_addr),
      .ram_rdata(ram_rdata), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .count(count), .empty(empty), .full(full),
      .overflow(overflow)
   );

   // Synchronous RAM plus the writer's wrapping address counter.
   data_t ram [DEPTH];
   addr_t wp;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp        <= '0;
         ram_rdata <= '0;
      end else begin
         if (rd_en) ram_rdata <= ram[rd_addr];
         if (wr_en) begin
            ram[wp] <= wdata;
            wp      <= wp + 10'd1;
         end
      end
   end

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: wq = words written but not yet read, bufq = words ready to stream.
   int    mc, cyc, first_wr, first_vld;
   addr_t eptr;
   bit    infl, ovf, exp_v, exp_pop, exp_rd, acc;
   data_t infl_d;
   data_t wq[$], bufq[$], popq[$], wlist[$];
   addr_t rdlog[$];
   int    rdcyc[$];

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         chk("rst_valid", out_valid, 0);
         chk("rst_rd_en", rd_en, 0);
         chk("rst_rd_addr", rd_addr, 0);
         chk("rst_count", count, 0);
         chk("rst_empty", empty, 1);
         chk("rst_full", full, 0);
         chk("rst_overflow", overflow, 0);
         chk("rst_out_data", out_data, 0);
         mc = 0; eptr = '0; infl = 0; ovf = 0;
         wq.delete(); bufq.delete();
      end else begin
         exp_v   = bufq.size() != 0;
         exp_pop = exp_v && out_ready;
         exp_rd  = (mc != 0) && (int'(bufq.size()) + int'(infl) - int'(exp_pop) < 2);
         chk("rd_en", rd_en, exp_rd);
         chk("rd_addr", rd_addr, eptr);
         chk("count", count, mc);
         chk("empty", empty, mc == 0);
         chk("full", full, mc == DEPTH);
         chk("overflow", overflow, ovf);
         chk("out_valid", out_valid, exp_v);
         if (exp_v) chk("out_data", out_data, bufq[0]);
         if (rd_en) begin rdlog.push_back(rd_addr); rdcyc.push_back(cyc); end
         if (wr_en && first_wr < 0) first_wr = cyc;
         if (out_valid && first_vld < 0) first_vld = cyc;
         if (exp_pop) begin popq.push_back(out_data); void'(bufq.pop_front()); end
         if (infl) bufq.push_back(infl_d);
         infl = exp_rd;
         if (exp_rd) begin infl_d = wq.pop_front(); eptr = eptr + 10'd1; mc--; end
         acc = wr_en && ((mc + int'(exp_rd)) < DEPTH || exp_rd);
         if (acc) begin wq.push_back(wdata); mc++; end
         if (wr_en && !acc) ovf = 1;
      end
   end

   task automatic drive(input bit w, input bit r, input data_t d);
      @(posedge clk); #1;
      wr_en = w; out_ready = r; wdata = d;
      if (w) wlist.push_back(d);
   endtask

   task automatic drain();
      int k = 0;
      do begin
         @(posedge clk); #1;
         wr_en = 0; out_ready = 1; k++;
      end while (k < 3000 && !(mc == 0 && bufq.size() == 0 && !infl));
      chk("drain_timeout", k < 3000, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      rst = 0; wr_en = 0; out_ready = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1;
   endtask

   int exp_wrap[4] = '{1022, 1023, 0, 1};
   int nw;

   initial begin
      first_wr = -1; first_vld = -1;
      repeat (3) @(posedge clk);
      #1 rst = 1;

      // Basic latency/order
      rdlog.delete(); rdcyc.delete(); popq.delete(); wlist.delete();
      for (int i = 0; i < 3; i++) drive(1, 1, 32'hA0 + i);
      drive(0, 1, '0);
      repeat (6) drive(0, 1, '0);
      chk("t1_nreads", rdlog.size(), 3);
      for (int i = 0; i < 3 && i < rdlog.size(); i++) begin
         chk("t1_addr", rdlog[i], i);
         chk("t1_consec", rdcyc[i] - rdcyc[0], i);
      end
      chk("t1_latency", first_vld - first_wr, 3);
      chk("t1_npop", popq.size(), 3);
      for (int i = 0; i < 3 && i < popq.size(); i++) chk("t1_data", popq[i], 32'hA0 + i);
      @(negedge clk);
      chk("t1_count", count, 0);
      chk("t1_empty", empty, 1);

      // Backpressure
      rdlog.delete(); popq.delete(); wlist.delete();
      for (int i = 0; i < 5; i++) drive(1, 0, $urandom);
      repeat (5) drive(0, 0, '0);
      @(negedge clk);
      chk("t2_nreads", rdlog.size(), 2);
      chk("t2_count", count, 3);
      chk("t2_rd_en", rd_en, 0);
      drain();
      chk("t2_npop", popq.size(), 5);
      for (int i = 0; i < 5 && i < popq.size(); i++) chk("t2_data", popq[i], wlist[i]);

      // Address wrap
      do_reset();
      for (int i = 0; i < 1022; i++) drive(1, 1, $urandom);
      drain();
      rdlog.delete();
      for (int i = 0; i < 4; i++) drive(1, 1, $urandom);
      drain();
      chk("t3_nreads", rdlog.size(), 4);
      for (int i = 0; i < 4 && i < rdlog.size(); i++) chk("t3_wrap", rdlog[i], exp_wrap[i]);

      // Full and overflow
      do_reset();
      for (int i = 0; i < 1026; i++) drive(1, 0, $urandom);
      drive(0, 0, '0);
      @(negedge clk);
      chk("t4_count", count, 1024);
      chk("t4_full", full, 1);
      chk("t4_ovf_clear", overflow, 0);
      drive(1, 0, $urandom);
      drive(0, 0, '0);
      @(negedge clk);
      chk("t4_ovf_set", overflow, 1);
      chk("t4_count_ovf", count, 1024);
      drive(1, 1, $urandom);
      @(negedge clk);
      chk("t4_sim_rd", rd_en, 1);
      drive(0, 0, '0);
      @(negedge clk);
      chk("t4_sim_count", count, 1024);
      chk("t4_sim_ovf", overflow, 1);
      do_reset();

      // Mid-stream reset
      for (int i = 0; i < 3; i++) drive(1, 0, $urandom);
      repeat (3) drive(0, 0, '0);
      @(posedge clk); #3;
      rst = 0;
      #1;
      chk("t5_valid_drop", out_valid, 0);
      chk("t5_count_drop", count, 0);
      chk("t5_empty", empty, 1);
      repeat (2) @(posedge clk);
      #1 rst = 1;
      rdlog.delete(); popq.delete(); wlist.delete();
      drive(1, 1, $urandom);
      drain();
      chk("t5_nreads", rdlog.size(), 1);
      if (rdlog.size() > 0) chk("t5_addr0", rdlog[0], 0);
      chk("t5_npop", popq.size(), 1);
      if (popq.size() > 0) chk("t5_data", popq[0], wlist[0]);

      // Random backpressure
      popq.delete(); wlist.delete();
      nw = 0;
      while (nw < 200) begin
         drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom);
         if (wr_en) nw++;
      end
      drain();
      chk("t6_npop", popq.size(), 200);
      for (int i = 0; i < 200 && i < popq.size(); i++) chk("t6_data", popq[i], wlist[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
